// File: rtl/crc_ctrl_pkg.sv
// crc_ctrl_pkg: state encoding and op codes shared by the CRC scheduler, the engine and the bench
package crc_ctrl_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;
endpackage

// File: rtl/crc_rr_arbiter2.sv
// crc_rr_arbiter2: 2-way round-robin arbiter; req/grant bit0=write bit1=read, advance enables grant and last_served update
module crc_rr_arbiter2
  import crc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic last_q;
  logic pick_rd;
  assign pick_rd = req[1] & (~req[0] | last_q == OP_WRITE);
  assign grant = advance ? {pick_rd, req[0] & ~pick_rd} : 2'b00;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= OP_READ;
    else if (|grant) last_q <= grant[1];
endmodule

// File: rtl/crc_shared_engine_scheduler.sv
// crc_shared_engine_scheduler: shares one serial CRC engine between write (encode) and read (check); write/read/crc_zero in, load_en/shift_en/sel_read to engine, write_mem_en/read_valid/read_crc_err/busy/req_drop status out
module crc_shared_engine_scheduler
  import crc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int CNT_W = $clog2(DATA_WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic write,
  input  logic read,
  input  logic crc_zero,
  output logic load_en,
  output logic shift_en,
  output logic sel_read,
  output logic write_mem_en,
  output logic read_valid,
  output logic read_crc_err,
  output logic busy,
  output logic req_drop
);
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sel_q, sel_d;
  logic wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic arb_en;
  logic [1:0] grant;
  assign arb_en = state_q == ST_IDLE || state_q == ST_DONE;
  crc_rr_arbiter2 u_arb (
    .clk(clk),
    .rst(rst),
    .req({rd_pend_q | read, wr_pend_q | write}),
    .advance(arb_en),
    .grant(grant)
  );
  always_comb begin
    wr_pend_d = grant[0] ? write & wr_pend_q : wr_pend_q | write;
    rd_pend_d = grant[1] ? read & rd_pend_q : rd_pend_q | read;
    req_drop = (write & wr_pend_q & ~grant[0]) | (read & rd_pend_q & ~grant[1]);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (|grant) begin
      state_d = ST_LOAD;
      sel_d = grant[OP_READ];
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_LOAD) begin
      state_d = ST_SHIFT;
      cnt_d = '0;
    end else if (state_q == ST_SHIFT) begin
      cnt_d = cnt_q + CNT_W'(1);
      state_d = cnt_q == CNT_W'(DATA_WIDTH - 1) ? ST_DONE : ST_SHIFT;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      sel_q <= OP_WRITE;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      wr_pend_q <= wr_pend_d;
      rd_pend_q <= rd_pend_d;
    end
  always_comb begin
    load_en = state_q == ST_LOAD;
    shift_en = state_q == ST_SHIFT;
    sel_read = sel_q;
    write_mem_en = state_q == ST_DONE && sel_q == OP_WRITE;
    read_valid = state_q == ST_DONE && sel_q == OP_READ;
    read_crc_err = state_q == ST_DONE && sel_q == OP_READ && !crc_zero;
    busy = state_q != ST_IDLE || wr_pend_q || rd_pend_q;
  end
endmodule
